// File: rtl/frame_controller.sv
// rtl/frame_controller.sv - frame buffer sequencer: load, per-pixel process, drain over UART
// Define FRAME_CHECKSUM_EN to append an 8-bit mod-256 sum byte after each drained frame.
module frame_controller #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tx_ready,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic [1:0]        proc_op,
    input  logic [7:0]        proc_thresh,
    output logic [1:0]        state,
    output logic              frame_done,
    output logic              overrun
);

    typedef enum logic [1:0] {S_IDLE = 2'b00, S_LOAD = 2'b01, S_PROC = 2'b10, S_DRAIN = 2'b11} state_t;
    typedef enum logic [1:0] {D_WAIT, D_ADDR, D_START, D_IGNORE} drain_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state, w_state;
    drain_t            r_dsub, w_dsub;
    logic [ADDR_W-1:0] r_cnt, w_cnt;
    logic              r_load_done, w_load_done;
    logic              r_pw, w_pw;
    logic [1:0]        r_op, w_op;
    logic [7:0]        r_thresh, w_thresh;
    logic              r_tx_start, w_tx_start;
    logic [7:0]        r_tx_byte, w_tx_byte;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_we, w_we;
    logic [7:0]        r_wdata, w_wdata;
    logic              r_frame_done, w_frame_done;
    logic              r_overrun, w_overrun;
    logic [7:0]        w_src;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        r_sum, w_sum;
    logic              r_cs, w_cs;
`endif

    function automatic logic [7:0] apply_op(input logic [1:0] op, input logic [7:0] th,
                                            input logic [7:0] p);
        case (op)
            2'b00:   apply_op = p;
            2'b01:   apply_op = 8'hFF - p;
            2'b10:   apply_op = (p >= th) ? 8'hFF : 8'h00;
            default: apply_op = p >> 1;
        endcase
    endfunction

`ifdef FRAME_CHECKSUM_EN
    assign w_src = r_cs ? r_sum : mem_rdata;
`else
    assign w_src = mem_rdata;
`endif

    // Synchronous RAM data only exists in the cycle after the address, so the write/launch
    // cycles pass it straight through; the registered copies hold it otherwise.
    assign tx_start   = r_tx_start;
    assign tx_byte    = r_tx_start ? w_src : r_tx_byte;
    assign mem_addr   = r_addr;
    assign mem_we     = r_we;
    assign mem_wdata  = (r_state == S_PROC && r_pw) ? apply_op(r_op, r_thresh, mem_rdata) : r_wdata;
    assign state      = r_state;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

    always_comb begin
        w_state      = r_state;
        w_dsub       = r_dsub;
        w_cnt        = r_cnt;
        w_load_done  = r_load_done;
        w_pw         = r_pw;
        w_op         = r_op;
        w_thresh     = r_thresh;
        w_tx_start   = 1'b0;
        w_tx_byte    = r_tx_byte;
        w_addr       = r_addr;
        w_we         = 1'b0;
        w_wdata      = r_wdata;
        w_frame_done = 1'b0;
        w_overrun    = r_overrun;
`ifdef FRAME_CHECKSUM_EN
        w_sum        = r_sum;
        w_cs         = r_cs;
`endif
        if (rx_valid && (r_state == S_PROC || r_state == S_DRAIN || r_load_done))
            w_overrun = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    w_addr    = '0;
                    w_we      = 1'b1;
                    w_wdata   = rx_byte;
                    w_overrun = 1'b0;
                    w_op      = proc_op;
                    w_thresh  = proc_thresh;
                    w_cnt     = ADDR_W'(1);
                    w_state   = S_LOAD;
                end
            end
            S_LOAD: begin
                // One settle cycle after the last write so PROCESS starts on a read.
                if (r_load_done) begin
                    w_load_done = 1'b0;
                    w_state     = S_PROC;
                    w_addr      = '0;
                    w_pw        = 1'b0;
                end else if (rx_valid) begin
                    w_addr  = r_cnt;
                    w_we    = 1'b1;
                    w_wdata = rx_byte;
                    if (r_cnt == LAST) begin
                        w_load_done = 1'b1;
                        w_cnt       = '0;
                    end else begin
                        w_cnt = r_cnt + ADDR_W'(1);
                    end
                end
            end
            S_PROC: begin
                if (!r_pw) begin
                    w_we = 1'b1;
                    w_pw = 1'b1;
                end else if (r_cnt == LAST) begin
                    w_state = S_DRAIN;
                    w_cnt   = '0;
                    w_dsub  = D_WAIT;
                    w_pw    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                    w_sum   = 8'h00;
                    w_cs    = 1'b0;
`endif
                end else begin
                    w_cnt  = r_cnt + ADDR_W'(1);
                    w_addr = r_cnt + ADDR_W'(1);
                    w_pw   = 1'b0;
                end
            end
            S_DRAIN: begin
                case (r_dsub)
                    D_WAIT: begin
                        if (tx_ready) begin
                            w_addr = r_cnt;
                            w_dsub = D_ADDR;
                        end
                    end
                    D_ADDR: begin
                        w_tx_start = 1'b1;
                        w_dsub     = D_START;
                    end
                    D_START: begin
                        w_tx_byte = w_src;
                        w_dsub    = D_IGNORE;
`ifdef FRAME_CHECKSUM_EN
                        if (r_cs) begin
                            w_frame_done = 1'b1;
                            w_state      = S_IDLE;
                            w_cs         = 1'b0;
                        end else begin
                            w_sum = r_sum + mem_rdata;
                            if (r_cnt == LAST) w_cs  = 1'b1;
                            else               w_cnt = r_cnt + ADDR_W'(1);
                        end
`else
                        if (r_cnt == LAST) begin
                            w_frame_done = 1'b1;
                            w_state      = S_IDLE;
                        end else begin
                            w_cnt = r_cnt + ADDR_W'(1);
                        end
`endif
                        if (w_state == S_IDLE) begin
                            w_cnt  = '0;
                            w_dsub = D_WAIT;
                        end
                    end
                    default: w_dsub = D_WAIT;
                endcase
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dsub       <= D_WAIT;
            r_cnt        <= '0;
            r_load_done  <= 1'b0;
            r_pw         <= 1'b0;
            r_op         <= 2'b00;
            r_thresh     <= 8'h00;
            r_tx_start   <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= 8'h00;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_sum        <= 8'h00;
            r_cs         <= 1'b0;
`endif
        end else begin
            r_state      <= w_state;
            r_dsub       <= w_dsub;
            r_cnt        <= w_cnt;
            r_load_done  <= w_load_done;
            r_pw         <= w_pw;
            r_op         <= w_op;
            r_thresh     <= w_thresh;
            r_tx_start   <= w_tx_start;
            r_tx_byte    <= w_tx_byte;
            r_addr       <= w_addr;
            r_we         <= w_we;
            r_wdata      <= w_wdata;
            r_frame_done <= w_frame_done;
            r_overrun    <= w_overrun;
`ifdef FRAME_CHECKSUM_EN
            r_sum        <= w_sum;
            r_cs         <= w_cs;
`endif
        end
    end

endmodule

// File: tb/tb_frame_controller.sv
// tb/tb_frame_controller.sv - scoreboard bench for frame_controller with DEPTH=4
module tb_frame_controller;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          tx_ready = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [1:0]    proc_op = 2'b00;
    logic [7:0]    proc_thresh = 8'h00;
    logic [1:0]    state;
    logic          frame_done;
    logic          overrun;

    frame_controller #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_ready(tx_ready),
        .tx_start(tx_start), .tx_byte(tx_byte), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .proc_op(proc_op),
        .proc_thresh(proc_thresh), .state(state), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    int         fd_cnt = 0;
    int         tx_cnt = 0;
    logic       hold_low = 1'b0;
    int         busy = 0;
    logic       have_launched = 1'b0;
    logic [7:0] last_tx = 8'h00;
    logic [7:0] mon_e;
    int         pcyc = 0;
    logic [1:0] prev_state = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy for a few cycles after each launch, or forced busy by hold_low.
    initial forever begin
        @(negedge clk);
        if (rst)             busy = 0;
        else if (tx_start)   busy = 4;
        else if (busy > 0)   busy--;
        tx_ready = !hold_low && (busy == 0);
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            have_launched = 1'b0;
            pcyc = 0;
        end else begin
            if (tx_start) begin
                tx_cnt++;
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected", 32'(tx_byte), 32'h100);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_byte", 32'(tx_byte), 32'(mon_e));
                end
                chk("tx_start_in_drain", 32'(state), 32'd3);
                last_tx = tx_byte;
                have_launched = 1'b1;
            end else if (have_launched) begin
                chk("tx_byte_stable", 32'(tx_byte), 32'(last_tx));
            end
            if (mem_we) chk("we_outside_drain", 32'(state == 2'b11), 32'd0);
            if (frame_done) begin
                fd_cnt++;
                chk("done_state_idle", 32'(state), 32'd0);
            end
            if (state == 2'b10) begin
                chk("proc_we_pattern", 32'(mem_we), 32'(pcyc % 2));
                pcyc++;
            end else if (prev_state == 2'b10) begin
                chk("proc_cycles", 32'(pcyc), 32'(2 * DEPTH));
                pcyc = 0;
            end
        end
        prev_state = state;
    end

    task automatic push_exp(input logic [31:0] ex);
        logic [7:0] sum;
        sum = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(ex[31-8*i -: 8]);
            sum = sum + ex[31-8*i -: 8];
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input int idx, input bit expect_write);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        if (expect_write) begin
            chk("load_we", 32'(mem_we), 32'd1);
            chk("load_addr", 32'(mem_addr), 32'(idx));
            chk("load_data", 32'(mem_wdata), 32'(b));
            if (idx == 0) begin
                chk("overrun_cleared", 32'(overrun), 32'd0);
                chk("state_load", 32'(state), 32'd1);
            end
            @(negedge clk);
            chk("load_we_one_cycle", 32'(mem_we), 32'd0);
        end else begin
            chk("overrun_set", 32'(overrun), 32'd1);
        end
    endtask

    task automatic load_frame(input logic [1:0] op, input logic [7:0] th, input logic [31:0] rx,
                              input logic [31:0] ex, input bit chg);
        proc_op     = op;
        proc_thresh = th;
        push_exp(ex);
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(rx[31-8*i -: 8], i, 1'b1);
            if (i == 0 && chg) begin
                proc_op     = 2'b11;
                proc_thresh = 8'h00;
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] s);
        int n;
        n = 0;
        while (state != s && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state_timeout", 32'(n < 2000), 32'd1);
    endtask

    task automatic finish_frame(input logic [31:0] ex);
        int f0;
        int n;
        f0 = fd_cnt;
        n = 0;
        while (fd_cnt == f0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done_timeout", 32'(n < 3000), 32'd1);
        repeat (5) @(negedge clk);
        chk("frame_done_once", 32'(fd_cnt - f0), 32'd1);
        chk("state_back_idle", 32'(state), 32'd0);
        chk("tx_queue_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) chk("ram_content", 32'(ram[i]), 32'(ex[31-8*i -: 8]));
    endtask

    initial begin
        int t0;
        int n;
        int f0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({state, tx_start, tx_byte, mem_addr, mem_we, mem_wdata,
                                  frame_done, overrun}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Invert.
        load_frame(2'b01, 8'h00, 32'h0010_80FF, 32'hFFEF_7F00, 1'b0);
        finish_frame(32'hFFEF_7F00);

        // Pass-through with a stray byte during PROCESS.
        load_frame(2'b00, 8'h00, 32'h1122_3344, 32'h1122_3344, 1'b0);
        wait_state(2'b10);
        send_byte(8'h55, 0, 1'b0);
        finish_frame(32'h1122_3344);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // Threshold, with op changed after the first byte.
        load_frame(2'b10, 8'h80, 32'h7F80_00FE, 32'h00FF_00FF, 1'b1);
        finish_frame(32'h00FF_00FF);

        // Halve, transmitter held busy at the start of DRAIN.
        hold_low = 1'b1;
        load_frame(2'b11, 8'h00, 32'h02FF_8140, 32'h017F_4020, 1'b0);
        wait_state(2'b11);
        t0 = tx_cnt;
        repeat (50) @(negedge clk);
        chk("no_tx_while_busy", 32'(tx_cnt - t0), 32'd0);
        hold_low = 1'b0;
        n = 0;
        while (tx_cnt == t0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tx_after_release_ge2", 32'(n >= 2 && n < 100), 32'd1);
        finish_frame(32'h017F_4020);

        // Reset during DRAIN after two bytes.
        load_frame(2'b00, 8'h00, 32'hA1B2_C3D4, 32'hA1B2_C3D4, 1'b0);
        t0 = tx_cnt;
        n = 0;
        while (tx_cnt < t0 + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("two_bytes_timeout", 32'(n < 2000), 32'd1);
        f0 = fd_cnt;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("reset_async_outputs", 32'({state, tx_start, tx_byte, mem_addr, mem_we, mem_wdata,
                                           frame_done, overrun}), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_after_abort", 32'(fd_cnt - f0), 32'd0);

        load_frame(2'b01, 8'h00, 32'h0102_0304, 32'hFEFD_FCFB, 1'b0);
        finish_frame(32'hFEFD_FCFB);

        // Pass-through whose checksum (when enabled) is 0x05.
        load_frame(2'b00, 8'h00, 32'h0102_03FF, 32'h0102_03FF, 1'b0);
        finish_frame(32'h0102_03FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
